// File: rtl/game_disp_pkg.sv
// Shared types, constants and the seven-segment glyph table for the game status display.
package game_disp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } conv_state_t;

  typedef struct packed {
    conv_state_t state;
    logic        busy;
    logic        done;
    logic [11:0] bcd;
  } disp_dbg_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam int         LANES     = 16;

  // Active-low {g,f,e,d,c,b,a}; letters render as A b C d E F.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/game_status_display_if.sv
// Game-state inputs and board-pin outputs of the status display.
interface game_status_display_if;
  // All signals are plain levels with no valid/ready: the game side holds score,
  // ss_front and e_life stable until it changes them, and the display samples continuously.
  logic [7:0]  score;
  logic [3:0]  ss_front;
  logic [31:0] e_life;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;
  logic [15:0] led;

  modport master (output score, ss_front, e_life, input seg, an, dp, led);
  modport slave  (input score, ss_front, e_life, output seg, an, dp, led);
endinterface

// File: rtl/game_status_display_bin2bcd_seq.sv
// Sequential double-dabble: one IDLE sample, eight adjust+shift cycles, one COMMIT.
module bin2bcd_seq
  import game_disp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  value,
  output logic        busy,
  output logic [11:0] bcd,
  output logic        done,
  output logic [7:0]  last_value,
  output conv_state_t state
);

  conv_state_t state_q, state_n;
  logic [7:0]  shift_q, shift_n, last_q, last_n;
  logic [11:0] scratch_q, scratch_n, bcd_q, bcd_n, adj;
  logic [2:0]  cnt_q, cnt_n;

  function automatic logic [3:0] dabble(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      bcd_q     <= '0;
      last_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_n;
      shift_q   <= shift_n;
      scratch_q <= scratch_n;
      bcd_q     <= bcd_n;
      last_q    <= last_n;
      cnt_q     <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    shift_n   = shift_q;
    scratch_n = scratch_q;
    bcd_n     = bcd_q;
    last_n    = last_q;
    cnt_n     = cnt_q;
    done      = 1'b0;
    adj       = {dabble(scratch_q[11:8]), dabble(scratch_q[7:4]), dabble(scratch_q[3:0])};
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_n   = value;
          last_n    = value;
          scratch_n = '0;
          cnt_n     = '0;
          state_n   = SHIFT;
        end
      end
      SHIFT: begin
        scratch_n = {adj[10:0], shift_q[7]};
        shift_n   = {shift_q[6:0], 1'b0};
        cnt_n     = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_n = COMMIT;
      end
      COMMIT: begin
        bcd_n   = scratch_q;
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign bcd        = bcd_q;
  assign last_value = last_q;
  assign state      = state_q;

endmodule

// File: rtl/game_status_display.sv
// Board-side reader of game state: multiplexed 4-digit display (lane hex + decimal score) and lane LEDs.
module game_status_display
  import game_disp_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                 clk,
  input  logic                 reset,
  game_status_display_if.slave bus,
  output disp_dbg_t            dbg
);

  localparam int SW = (SCAN_DIV  > 2) ? $clog2(SCAN_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  logic [SW-1:0] scan_cnt;
  logic [BW-1:0] blink_cnt;
  logic [1:0]    digit_idx;
  logic          blink_phase;
  logic [6:0]    seg_q, seg_n;
  logic [3:0]    an_q;
  logic          dp_q, dp_n;
  logic [15:0]   led_q, led_n;
  logic [11:0]   bcd;
  logic [7:0]    last_value;
  logic          conv_busy, conv_done;
  conv_state_t   conv_state;

  bin2bcd_seq u_bcd (
    .clk        (clk),
    .reset      (reset),
    .start      (bus.score != last_value),
    .value      (bus.score),
    .busy       (conv_busy),
    .bcd        (bcd),
    .done       (conv_done),
    .last_value (last_value),
    .state      (conv_state)
  );

  // Leading-zero blanking: ones always lit so a zero score still reads "0".
  always_comb begin
    seg_n = SEG_BLANK;
    dp_n  = 1'b1;
    case (digit_idx)
      2'd3: begin
        seg_n = hex_to_seg(bus.ss_front);
        dp_n  = 1'b0;
      end
      2'd2: seg_n = (bcd[11:8] == 4'd0) ? SEG_BLANK : hex_to_seg(bcd[11:8]);
      2'd1: seg_n = (bcd[11:4] == 8'd0) ? SEG_BLANK : hex_to_seg(bcd[7:4]);
      default: seg_n = hex_to_seg(bcd[3:0]);
    endcase
  end

  always_comb begin
    led_n = '0;
    for (int i = 0; i < LANES; i++) begin
      case (bus.e_life[2*i +: 2])
        2'd0:    led_n[i] = 1'b0;
        2'd1:    led_n[i] = blink_phase;
        default: led_n[i] = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt    <= '0;
      blink_cnt   <= '0;
      digit_idx   <= '0;
      blink_phase <= 1'b0;
      seg_q       <= SEG_BLANK;
      an_q        <= 4'hF;
      dp_q        <= 1'b1;
      led_q       <= '0;
    end else begin
      if (scan_cnt == SW'(SCAN_DIV - 1)) begin
        scan_cnt  <= '0;
        digit_idx <= digit_idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      if (blink_cnt == BW'(BLINK_DIV - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
      seg_q <= seg_n;
      an_q  <= ~(4'b0001 << digit_idx);
      dp_q  <= dp_n;
      led_q <= led_n;
    end
  end

  assign bus.seg = seg_q;
  assign bus.an  = an_q;
  assign bus.dp  = dp_q;
  assign bus.led = led_q;

  assign dbg.state = conv_state;
  assign dbg.busy  = conv_busy;
  assign dbg.done  = conv_done;
  assign dbg.bcd   = bcd;

endmodule

// File: tb/tb_game_status_display.sv
// Directed bench for game_status_display with SCAN_DIV=4, BLINK_DIV=8.
module tb_game_status_display;
  import game_disp_pkg::*;

  logic      clk;
  logic      reset;
  int        cyc;
  int        vectors;
  int        miscompares;
  disp_dbg_t dbg;

  game_status_display_if bus();

  game_status_display #(.SCAN_DIV(4), .BLINK_DIV(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .dbg   (dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Post-release edge count, used to predict scan and blink phase.
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_digit(input int d, input logic [6:0] exp_seg, input logic exp_dp,
                            input string tag);
    logic [3:0] want;
    int n;
    want = ~(4'b0001 << d);
    n = 0;
    while (bus.an !== want && n < 32) begin
      tick(1);
      n++;
    end
    check({tag, "_an"}, {28'b0, bus.an}, {28'b0, want});
    check({tag, "_seg"}, {25'b0, bus.seg}, {25'b0, exp_seg});
    check({tag, "_dp"}, {31'b0, bus.dp}, {31'b0, exp_dp});
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_seg"}, {25'b0, bus.seg}, 32'h7F);
    check({tag, "_an"}, {28'b0, bus.an}, 32'hF);
    check({tag, "_dp"}, {31'b0, bus.dp}, 32'h1);
    check({tag, "_led"}, {16'b0, bus.led}, 32'h0);
    check({tag, "_st"}, {30'b0, dbg.state}, {30'b0, IDLE});
  endtask

  initial begin
    logic [3:0] an_exp;
    logic       ph;
    vectors      = 0;
    miscompares  = 0;
    reset        = 1'b1;
    bus.score    = 8'd0;
    bus.ss_front = 4'h0;
    bus.e_life   = 32'h0;

    // Reset held three cycles
    tick(3);
    check_reset_vals("rst");
    check("rst_bcd", {20'b0, dbg.bcd}, 32'h0);
    reset = 1'b0;

    // Anode scan E,D,B,7 every 4 clocks
    for (int k = 0; k < 16; k++) begin
      tick(1);
      an_exp = ~(4'b0001 << (((cyc - 1) / 4) % 4));
      check("scan_an", {28'b0, bus.an}, {28'b0, an_exp});
    end
    wait_digit(0, 7'h40, 1'b1, "zero_d0");
    wait_digit(1, 7'h7F, 1'b1, "zero_d1");
    wait_digit(2, 7'h7F, 1'b1, "zero_d2");
    wait_digit(3, 7'h40, 1'b0, "zero_d3");

    // Score 255: exact 10-cycle latency
    tick(1);
    bus.score = 8'd255;
    tick(9);
    check("bcd255_early", {20'b0, dbg.bcd}, 32'h000);
    tick(1);
    check("bcd255", {20'b0, dbg.bcd}, 32'h255);
    check("st_after255", {30'b0, dbg.state}, {30'b0, IDLE});
    wait_digit(2, 7'h24, 1'b1, "s255_d2");
    wait_digit(1, 7'h12, 1'b1, "s255_d1");
    wait_digit(0, 7'h12, 1'b1, "s255_d0");

    // Score 7 then 130 three cycles into the conversion
    tick(1);
    bus.score = 8'd7;
    tick(3);
    check("st_shift", {30'b0, dbg.state}, {30'b0, SHIFT});
    bus.score = 8'd130;
    tick(5);
    check("bcd7_early", {20'b0, dbg.bcd}, 32'h255);
    tick(2);
    check("bcd7", {20'b0, dbg.bcd}, 32'h007);
    tick(9);
    check("bcd130_early", {20'b0, dbg.bcd}, 32'h007);
    tick(1);
    check("bcd130", {20'b0, dbg.bcd}, 32'h130);
    wait_digit(2, 7'h79, 1'b1, "s130_d2");
    wait_digit(1, 7'h30, 1'b1, "s130_d1");
    wait_digit(0, 7'h40, 1'b1, "s130_d0");

    // Ship lane B on digit 3 with decimal point
    bus.ss_front = 4'hB;
    tick(2);
    wait_digit(3, 7'h03, 1'b0, "lane_b_d3");
    wait_digit(0, 7'h40, 1'b1, "lane_b_d0");

    // Lane LEDs: lane0 blinks, lanes 5 and 9 steady
    bus.e_life = 32'h0008_0C01;
    tick(1);
    for (int k = 0; k < 24; k++) begin
      tick(1);
      ph = (((cyc - 1) / 8) % 2) != 0;
      check("led", {16'b0, bus.led}, {16'b0, 16'h0220 | {15'b0, ph}});
    end

    // Reset pulsed mid-conversion of 99
    bus.score = 8'd99;
    tick(4);
    check("st_shift99", {30'b0, dbg.state}, {30'b0, SHIFT});
    reset = 1'b1;
    tick(1);
    check_reset_vals("rst2");
    check("rst2_bcd", {20'b0, dbg.bcd}, 32'h0);
    tick(1);
    reset = 1'b0;
    tick(9);
    check("bcd99_early", {20'b0, dbg.bcd}, 32'h000);
    tick(1);
    check("bcd99", {20'b0, dbg.bcd}, 32'h099);
    wait_digit(2, 7'h7F, 1'b1, "s99_d2");
    wait_digit(1, 7'h10, 1'b1, "s99_d1");
    wait_digit(0, 7'h10, 1'b1, "s99_d0");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
